reg_op_ctrl: RTL and testbench

REG_OP_CTRL -- requirements
Module: reg_op_ctrl

---
 rtl/reg_op_ctrl.sv | 82 ++++++++
 tb/tb_reg_op_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_ctrl.sv
// reg_op_ctrl: multi-cycle ADD/AND/NOT/read-out sequencer driving a register file
// through SR1/SR2 selects and a one-cycle LD_REG write-back.
module reg_op_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] IR,
  input  logic [15:0] SR1_OUT,
  input  logic [15:0] SR2_OUT,
  output logic        SR1,
  output logic        DR,
  output logic [2:0]  SR2,
  output logic        LD_REG,
  output logic [15:0] BUS,
  output logic [2:0]  NZP,
  output logic [15:0] Rd_Data,
  output logic        Busy,
  output logic        Done,
  output logic        Illegal
);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WRITE, DONE} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_ir, r_bus, r_rd;
  logic [2:0]  r_nzp;
  logic [3:0]  w_op;
  logic        w_alu, w_rd, w_legal;
  logic [15:0] w_b, w_res;
  assign w_op    = r_ir[15:12];
  assign w_alu   = (w_op == 4'b0001) || (w_op == 4'b0101) || (w_op == 4'b1001);
  assign w_rd    = w_op == 4'b0011;
  assign w_legal = w_alu || w_rd;
  assign w_b     = r_ir[5] ? {{11{r_ir[4]}}, r_ir[4:0]} : SR2_OUT;
  assign w_res   = (w_op == 4'b0001) ? SR1_OUT + w_b :
                   (w_op == 4'b0101) ? SR1_OUT & w_b : ~SR1_OUT;
  always_comb begin
    w_next  = r_state;
    SR1     = 1'b0;
    DR      = 1'b0;
    SR2     = r_ir[2:0];
    LD_REG  = 1'b0;
    BUS     = r_bus;
    NZP     = r_nzp;
    Rd_Data = r_rd;
    Busy    = r_state != IDLE;
    Done    = r_state == DONE;
    Illegal = (r_state == DONE) && !w_legal;
    case (r_state)
      IDLE:    w_next = Start ? DECODE : IDLE;
      DECODE: begin
        SR1    = w_rd;
        w_next = w_legal ? EXEC : DONE;
      end
      EXEC: begin
        SR1    = w_rd;
        w_next = WRITE;
      end
      WRITE: begin
        LD_REG = w_alu;
        w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_ir    <= '0;
      r_bus   <= '0;
      r_rd    <= '0;
      r_nzp   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && Start) r_ir <= IR;
      if (r_state == EXEC && w_alu) begin
        r_bus <= w_res;
        r_nzp <= w_res[15] ? 3'b100 : (w_res == '0) ? 3'b010 : 3'b001;
      end
      if (r_state == EXEC && w_rd) r_rd <= SR1_OUT;
    end
  end
endmodule

// File: tb/tb_reg_op_ctrl.sv
// tb_reg_op_ctrl: random and directed stimulus checked every cycle against a
// transaction-timeline model of reg_op_ctrl with an attached register file.
module tb_reg_op_ctrl;
  logic        Clk = 0, Reset, Start;
  logic [15:0] IR, SR1_OUT, SR2_OUT;
  logic        SR1, DR, LD_REG, Busy, Done, Illegal;
  logic [2:0]  SR2, NZP;
  logic [15:0] BUS, Rd_Data;
  int n_cmp = 0, n_bad = 0;

  reg_op_ctrl dut (.Clk(Clk), .Reset(Reset), .Start(Start), .IR(IR),
    .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT), .SR1(SR1), .DR(DR), .SR2(SR2),
    .LD_REG(LD_REG), .BUS(BUS), .NZP(NZP), .Rd_Data(Rd_Data), .Busy(Busy),
    .Done(Done), .Illegal(Illegal));

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] cc(input logic [15:0] v);
    return v[15] ? 3'b100 : (v == 16'h0) ? 3'b010 : 3'b001;
  endfunction

  // Preload port shared by the bench register file and the model's copy.
  logic        pl_en = 0;
  logic [2:0]  pl_idx;
  logic [15:0] pl_val;

  // Model: on acceptance the whole outcome is computed at once; the offset m_d
  // since acceptance decides when each effect must be visible.
  logic [15:0] m_regs [8];
  logic [15:0] m_ir = 0, old_bus = 0, new_bus = 0, old_rd = 0, new_rd = 0;
  logic [2:0]  old_nzp = 0, new_nzp = 0, m_sr2 = 0;
  bit          m_init = 0, m_act = 0, m_alu = 0, m_isrd = 0, m_legal = 0;
  int          m_d = 0, m_last = 0;

  always @(posedge Clk) begin : model
    logic [15:0] a, b;
    logic [3:0]  op;
    bit          idle;
    idle = !m_act;
    if (pl_en) m_regs[pl_idx] = pl_val;
    if (m_act) begin
      if (m_d == 2 && m_alu) m_regs[m_ir[11:9]] = new_bus;
      m_d++;
      if (m_d > m_last) begin
        m_act = 0; old_bus = new_bus; old_nzp = new_nzp; old_rd = new_rd;
      end
    end
    if (Reset) begin
      m_init = 1; m_act = 0; m_sr2 = 0;
      old_bus = 0; new_bus = 0; old_nzp = 0; new_nzp = 0; old_rd = 0; new_rd = 0;
    end else if (idle && Start && m_init) begin
      m_ir    = IR;
      m_sr2   = IR[2:0];
      op      = IR[15:12];
      m_alu   = op == 4'd1 || op == 4'd5 || op == 4'd9;
      m_isrd  = op == 4'd3;
      m_legal = m_alu || m_isrd;
      m_last  = m_legal ? 3 : 1;
      m_d     = 0;
      m_act   = 1;
      a = m_regs[m_isrd ? IR[11:9] : IR[8:6]];
      b = IR[5] ? {{11{IR[4]}}, IR[4:0]} : m_regs[IR[2:0]];
      new_bus = op == 4'd1 ? a + b : op == 4'd5 ? (a & b) : op == 4'd9 ? ~a : old_bus;
      new_nzp = m_alu ? cc(new_bus) : old_nzp;
      new_rd  = m_isrd ? a : old_rd;
    end
  end

  // Register file environment written by the DUT's own write-back.
  logic [15:0] rf [8];
  always_comb begin
    SR1_OUT = rf[SR1 ? m_ir[11:9] : m_ir[8:6]];
    SR2_OUT = rf[SR2];
  end
  always @(posedge Clk) begin
    if (pl_en) rf[pl_idx] <= pl_val;
    if (LD_REG) rf[DR ? 3'd7 : m_ir[11:9]] <= BUS;
  end

  always @(negedge Clk) if (m_init) begin
    chk("busy", 16'(Busy), 16'(m_act));
    chk("done", 16'(Done), 16'(m_act && m_d == m_last));
    chk("illegal", 16'(Illegal), 16'(m_act && !m_legal && m_d == 1));
    chk("ld_reg", 16'(LD_REG), 16'(m_act && m_alu && m_d == 2));
    chk("dr", 16'(DR), 16'(0));
    chk("sr2", 16'(SR2), 16'(m_sr2));
    if (m_act && m_d == 0) chk("sr1_decode", 16'(SR1), 16'(m_isrd));
    chk("bus", BUS, (m_act && m_d >= 2) ? new_bus : old_bus);
    chk("nzp", 16'(NZP), 16'((m_act && m_d >= 2) ? new_nzp : old_nzp));
    chk("rd_data", Rd_Data, (m_act && m_d >= 2) ? new_rd : old_rd);
  end

  task automatic tick;
    @(posedge Clk);
    #2;
  endtask

  task automatic preload(input logic [2:0] idx, input logic [15:0] val);
    pl_en = 1; pl_idx = idx; pl_val = val;
    tick;
    pl_en = 0;
  endtask

  task automatic run(input logic [15:0] ir, output int lat, output int lds,
                     output logic sr1d, output logic ill);
    IR = ir; Start = 1;
    tick;
    Start = 0; IR = 16'($urandom);
    lat = 0; lds = 0; sr1d = 0; ill = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge Clk);
      if (n == 1) sr1d = SR1;
      if (LD_REG) lds++;
      if (Done) begin lat = n; ill = Illegal; break; end
    end
    tick;
  endtask

  function automatic logic [3:0] pick_op();
    case ($urandom_range(0, 4))
      0: return 4'd1;
      1: return 4'd5;
      2: return 4'd9;
      3: return 4'd3;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    int lat, lds;
    logic sr1d, ill;
    Reset = 1; Start = 1; IR = 16'h1642;
    tick;
    Start = 0;
    tick;
    Reset = 0;
    @(negedge Clk);
    chk("rst_busy", 16'(Busy), 16'h0);
    chk("rst_bus", BUS, 16'h0);
    chk("rst_nzp", 16'(NZP), 16'h0);
    chk("rst_rd", Rd_Data, 16'h0);
    chk("rst_sr1", 16'(SR1), 16'h0);
    chk("rst_sr2", 16'(SR2), 16'h0);
    chk("rst_done", 16'(Done), 16'h0);
    tick;
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    run(16'h1642, lat, lds, sr1d, ill);
    chk("add_lat", 16'(lat), 16'd4);
    chk("add_lds", 16'(lds), 16'd1);
    chk("add_bus", BUS, 16'h0008);
    chk("add_nzp", 16'(NZP), 16'h1);
    run(16'h1A70, lat, lds, sr1d, ill);
    chk("addi_bus", BUS, 16'hFFF5);
    chk("addi_nzp", 16'(NZP), 16'h4);
    run(16'h5020, lat, lds, sr1d, ill);
    chk("and0_bus", BUS, 16'h0000);
    chk("and0_nzp", 16'(NZP), 16'h2);
    run(16'h987F, lat, lds, sr1d, ill);
    chk("not_bus", BUS, 16'hFFFA);
    chk("not_nzp", 16'(NZP), 16'h4);
    chk("not_sr1", 16'(sr1d), 16'h0);
    preload(3'd3, 16'h1234);
    run(16'h3600, lat, lds, sr1d, ill);
    chk("rd_sr1", 16'(sr1d), 16'h1);
    chk("rd_data", Rd_Data, 16'h1234);
    chk("rd_lds", 16'(lds), 16'h0);
    chk("rd_nzp", 16'(NZP), 16'h4);
    chk("rd_lat", 16'(lat), 16'd4);
    IR = 16'hD000; Start = 1;
    tick;
    @(negedge Clk);
    chk("ill_done_early", 16'(Done), 16'h0);
    tick;
    @(negedge Clk);
    chk("ill_done", 16'(Done), 16'h1);
    chk("ill_flag", 16'(Illegal), 16'h1);
    tick;
    Start = 0;
    @(negedge Clk);
    chk("ill_ignored_start", 16'(Busy), 16'h0);
    chk("ill_bus_hold", BUS, 16'hFFFA);
    tick;
    IR = 16'h1642; Start = 1;
    tick;
    Start = 0;
    tick;
    tick;
    Reset = 1;
    @(negedge Clk);
    chk("wr_ld", 16'(LD_REG), 16'h1);
    tick;
    Reset = 0;
    @(negedge Clk);
    chk("rstw_ld", 16'(LD_REG), 16'h0);
    chk("rstw_busy", 16'(Busy), 16'h0);
    chk("rstw_bus", BUS, 16'h0);
    chk("rstw_nzp", 16'(NZP), 16'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("rstw_no_done", 16'(Done), 16'h0);
    end
    tick;
    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
    for (int i = 0; i < 3000; i++) begin
      Start = $urandom_range(0, 2) == 0;
      IR    = {pick_op(), 12'($urandom)};
      Reset = $urandom_range(0, 79) == 0;
      tick;
    end
    Start = 0; Reset = 0;
    repeat (10) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
